// File: rtl/seg14_pkg.sv
// Shared definitions for the 14-segment scroll controller:
// character codes, the scan state encoding and the character font.
package seg14_pkg;

    localparam int CHAR_W  = 6;
    localparam int SEG_W   = 14;
    localparam int N_CODES = 64;

    // Code 0 is a blank; 1..26 are A..Z, 27..36 are 0..9, the rest are blank.
    localparam logic [CHAR_W-1:0] CH_SPACE = 6'd0;
    localparam logic [CHAR_W-1:0] CH_LAST  = 6'd36;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Bit order, MSB first: a b c d e f g1 g2 h i j k l m
    localparam logic [SEG_W-1:0] FONT [N_CODES] = '{
        14'b00000000000000,                                         // space
        14'b11101111000000, 14'b11110001010010, 14'b10011100000000, // A B C
        14'b11110000010010, 14'b10011110000000, 14'b10001110000000, // D E F
        14'b10111101000000, 14'b01101111000000, 14'b10010000010010, // G H I
        14'b01111000000000, 14'b00001110001100, 14'b00011100000000, // J K L
        14'b01101100101000, 14'b01101100100100, 14'b11111100000000, // M N O
        14'b11001111000000, 14'b11111100000100, 14'b11001111000100, // P Q R
        14'b10110111000000, 14'b10000000010010, 14'b01111100000000, // S T U
        14'b00001100001001, 14'b01101100000101, 14'b00000000101101, // V W X
        14'b00000000101010, 14'b10010000001001,                     // Y Z
        14'b11111100001001, 14'b01100000001000, 14'b11011011000000, // 0 1 2
        14'b11110011000000, 14'b01100111000000, 14'b10110111000000, // 3 4 5
        14'b10111111000000, 14'b11100000000000, 14'b11111111000000, // 6 7 8
        14'b11110111000000,                                         // 9
        14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0,
        14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0,
        14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0
    };

endpackage

// File: rtl/seg14_font.sv
// Combinational character code to 14-segment pattern lookup.
module seg14_font
    import seg14_pkg::*;
(
    input  logic [CHAR_W-1:0] code,
    output logic [SEG_W-1:0]  pattern
);

    // Codes beyond the digit range always render blank.
    always_comb begin
        pattern = FONT[code];
        if (code > CH_LAST) begin
            pattern = '0;
        end
    end

endmodule

// File: rtl/seg14_scroll_ctrl.sv
// Multiplexed 14-segment display driver: host-writable message buffer,
// digit scan with prescaler, optional scrolling and registered outputs.
module seg14_scroll_ctrl
    import seg14_pkg::*;
#(
    parameter int N_DIGITS   = 12,
    parameter int MSG_DEPTH  = 32,
    parameter int SCAN_DIV   = 1024,
    parameter int SCROLL_DIV = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           scroll_en,
    input  logic                           wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0]   wr_addr,
    input  logic [CHAR_W-1:0]              wr_char,
    input  logic [$clog2(MSG_DEPTH+1)-1:0] cfg_len,
    output logic [N_DIGITS-1:0]            sel,
    output logic [SEG_W-1:0]               segm,
    output logic                           frame_done
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int LW = $clog2(MSG_DEPTH + 1);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(N_DIGITS);
    localparam int FW = $clog2(SCROLL_DIV + 1);

    state_t            state;
    logic [PW-1:0]     presc;
    logic [DW-1:0]     digit;
    logic [FW-1:0]     frame_cnt;
    logic [LW-1:0]     offset;
    logic [LW-1:0]     len_q;
    logic [CHAR_W-1:0] msg_q [MSG_DEPTH];

    logic              presc_tc;
    logic              digit_last;
    logic              scanning;
    logic              addr_ok;
    logic [LW-1:0]     len_clamp;
    logic [LW-1:0]     off_base;
    logic [LW-1:0]     off_step;
    logic [AW-1:0]     rd_idx;
    logic              show;
    int                sum;
    logic [CHAR_W-1:0] char_code;
    logic [SEG_W-1:0]  font_pat;

    assign scanning   = (state == RUN) && en;
    assign presc_tc   = (presc == PW'(SCAN_DIV - 1));
    assign digit_last = (digit == DW'(N_DIGITS - 1));
    assign frame_done = scanning && presc_tc && digit_last;
    assign addr_ok    = (32'(wr_addr) < 32'(MSG_DEPTH));
    assign len_clamp  = (cfg_len > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : cfg_len;

    // Offset at a frame boundary: pulled back inside the new length, then stepped with wrap.
    always_comb begin
        off_base = (offset >= len_clamp) ? '0 : offset;
        off_step = off_base + 1'b1;
        if (off_step >= len_clamp) begin
            off_step = '0;
        end
    end

    // Buffer slot shown on the digit currently being scanned.
    always_comb begin
        rd_idx = '0;
        show   = 1'b0;
        sum    = 0;
        if (len_q != '0) begin
            if (scroll_en) begin
                sum    = int'(offset) + int'(digit);
                rd_idx = AW'(sum % int'(len_q));
                show   = 1'b1;
            end else if (int'(digit) < int'(len_q)) begin
                rd_idx = AW'(digit);
                show   = 1'b1;
            end
        end
    end

    assign char_code = show ? msg_q[rd_idx] : CH_SPACE;

    seg14_font u_font (
        .code    (char_code),
        .pattern (font_pat)
    );

    // Message buffer: reset to blanks, writes land at the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MSG_DEPTH; i++) begin
                msg_q[i] <= CH_SPACE;
            end
        end else if (wr_en && addr_ok) begin
            msg_q[wr_addr] <= wr_char;
        end
    end

    // Scan FSM, prescaler, digit index, and frame-boundary length/scroll updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            presc     <= '0;
            digit     <= '0;
            frame_cnt <= '0;
            offset    <= '0;
            len_q     <= '0;
        end else if (state == IDLE) begin
            presc <= '0;
            digit <= '0;
            if (en) begin
                state <= RUN;
            end
        end else if (!en) begin
            state <= IDLE;
            presc <= '0;
            digit <= '0;
        end else if (!presc_tc) begin
            presc <= presc + 1'b1;
        end else begin
            presc <= '0;
            if (!digit_last) begin
                digit <= digit + 1'b1;
            end else begin
                digit <= '0;
                len_q <= len_clamp;
                if (!scroll_en) begin
                    frame_cnt <= '0;
                    offset    <= '0;
                end else if (frame_cnt == FW'(SCROLL_DIV - 1)) begin
                    frame_cnt <= '0;
                    offset    <= off_step;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                    offset    <= off_base;
                end
            end
        end
    end

    // Registered display drive; blank unless actively scanning.
    always_ff @(posedge clk) begin
        if (rst || !scanning) begin
            sel  <= '0;
            segm <= '0;
        end else begin
            sel  <= N_DIGITS'(1) << digit;
            segm <= font_pat;
        end
    end

endmodule
